// File: rtl/branch_resolve_e1_if.sv
// branch_resolve_e1_if: E1 resolve inputs, fetch BHT lookup and redirect/flush outputs
interface branch_resolve_e1_if;
  logic        valid_e1;
  logic        stall_i;
  logic [1:0]  branch_e1;
  logic        jump_e1;
  logic        jalr_e1;
  logic [31:0] rd1_e1;
  logic [31:0] rd2_e1;
  logic [31:0] pc_e1;
  logic [31:0] imm_ext_e1;
  logic [31:0] pc_plus4_e1;
  logic        pred_taken_e1;
  logic [31:0] pred_pc_e1;
  logic [31:0] lookup_pc_i;
  logic        lookup_taken_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic [31:0] branch_count_o;
  logic [31:0] mispredict_count_o;
  modport master (
    output valid_e1, stall_i, branch_e1, jump_e1, jalr_e1, rd1_e1, rd2_e1, pc_e1,
           imm_ext_e1, pc_plus4_e1, pred_taken_e1, pred_pc_e1, lookup_pc_i,
    input  lookup_taken_o, redirect_valid_o, redirect_pc_o, flush_o,
           branch_count_o, mispredict_count_o
  );
  modport slave (
    input  valid_e1, stall_i, branch_e1, jump_e1, jalr_e1, rd1_e1, rd2_e1, pc_e1,
           imm_ext_e1, pc_plus4_e1, pred_taken_e1, pred_pc_e1, lookup_pc_i,
    output lookup_taken_o, redirect_valid_o, redirect_pc_o, flush_o,
           branch_count_o, mispredict_count_o
  );
endinterface

// File: rtl/branch_resolve_e1.sv
// branch_resolve_e1: E1 branch/jump resolution, redirect+flush and 2-bit BHT; BRANCH_PERF_EN adds perf counters
module branch_resolve_e1 #(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input logic               clk,
  input logic               rst,
  branch_resolve_e1_if.slave bus
);
  logic [1:0]       bht [BHT_ENTRIES];
  logic             is_branch;
  logic             cond;
  logic             actual_taken;
  logic             resolve;
  logic             mispredict;
  logic             bht_we;
  logic [31:0]      target;
  logic [31:0]      next_pc;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] lk_idx;
  logic             redirect_q;
  logic [31:0]      redirect_pc_q;
  logic             unused_bits;
  always_comb begin
    is_branch    = bus.branch_e1 != 2'b00;
    cond         = bus.branch_e1 == 2'b01 ? bus.rd1_e1 == bus.rd2_e1 :
                   bus.branch_e1 == 2'b10 ? bus.rd1_e1 != bus.rd2_e1 :
                   bus.branch_e1 == 2'b11 ? $signed(bus.rd1_e1) < $signed(bus.rd2_e1) : 1'b0;
    actual_taken = bus.jump_e1 | cond;
    target       = (bus.jalr_e1 & bus.jump_e1) ? ((bus.rd1_e1 + bus.imm_ext_e1) & ~32'h1)
                                               : bus.pc_e1 + bus.imm_ext_e1;
    next_pc      = actual_taken ? target : bus.pc_plus4_e1;
    resolve      = bus.valid_e1 & ~bus.stall_i & ~redirect_q &
                   (is_branch | bus.jump_e1 | bus.pred_taken_e1);
    mispredict   = resolve & ((actual_taken != bus.pred_taken_e1) |
                   (actual_taken & bus.pred_taken_e1 & (target != bus.pred_pc_e1)));
    bht_we       = resolve & is_branch & ~bus.jump_e1;
    upd_idx      = bus.pc_e1[IDX_W+1:2];
    lk_idx       = bus.lookup_pc_i[IDX_W+1:2];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'h0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else begin
      redirect_q <= mispredict;
      if (mispredict) redirect_pc_q <= next_pc;
      if (bht_we) bht[upd_idx] <= actual_taken ? (bht[upd_idx] == 2'b11 ? 2'b11 : bht[upd_idx] + 2'b01)
                                               : (bht[upd_idx] == 2'b00 ? 2'b00 : bht[upd_idx] - 2'b01);
    end
  end
  assign bus.lookup_taken_o   = bht[lk_idx][1];
  assign bus.redirect_valid_o = redirect_q;
  assign bus.flush_o          = redirect_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign unused_bits = ^{bus.lookup_pc_i[31:IDX_W+2], bus.lookup_pc_i[1:0]};
`ifdef BRANCH_PERF_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      branch_cnt     <= 32'h0;
      mispredict_cnt <= 32'h0;
    end else begin
      if (resolve & (is_branch | bus.jump_e1)) branch_cnt <= branch_cnt + 32'h1;
      if (mispredict) mispredict_cnt <= mispredict_cnt + 32'h1;
    end
  end
  assign bus.branch_count_o     = branch_cnt;
  assign bus.mispredict_count_o = mispredict_cnt;
`else
  assign bus.branch_count_o     = 32'h0;
  assign bus.mispredict_count_o = 32'h0;
`endif
endmodule

// File: tb/tb_branch_resolve_e1.sv
// tb_branch_resolve_e1: directed self-checking bench for branch_resolve_e1
module tb_branch_resolve_e1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
`ifdef BRANCH_PERF_EN
  localparam logic [31:0] EXP_BC = 32'd4;
  localparam logic [31:0] EXP_MC = 32'd1;
`else
  localparam logic [31:0] EXP_BC = 32'd0;
  localparam logic [31:0] EXP_MC = 32'd0;
`endif
  branch_resolve_e1_if bus();
  branch_resolve_e1 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.valid_e1      = 1'b0;
    bus.stall_i       = 1'b0;
    bus.branch_e1     = 2'b00;
    bus.jump_e1       = 1'b0;
    bus.jalr_e1       = 1'b0;
    bus.rd1_e1        = 32'h0;
    bus.rd2_e1        = 32'h0;
    bus.pc_e1         = 32'h0;
    bus.imm_ext_e1    = 32'h0;
    bus.pc_plus4_e1   = 32'h4;
    bus.pred_taken_e1 = 1'b0;
    bus.pred_pc_e1    = 32'h0;
  endtask
  task automatic drive(input logic [1:0] br, input logic j, input logic jr,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pt, input logic [31:0] ppc);
    bus.valid_e1      = 1'b1;
    bus.stall_i       = 1'b0;
    bus.branch_e1     = br;
    bus.jump_e1       = j;
    bus.jalr_e1       = jr;
    bus.rd1_e1        = a;
    bus.rd2_e1        = b;
    bus.pc_e1         = pc;
    bus.imm_ext_e1    = imm;
    bus.pc_plus4_e1   = pc + 32'h4;
    bus.pred_taken_e1 = pt;
    bus.pred_pc_e1    = ppc;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    idle();
    bus.lookup_pc_i = 32'h100;
    tick();
    tick();
    checks++; if (bus.lookup_taken_o !== 1'b0) begin errors++; $display("FAIL reset_lookup: got %b want 0", bus.lookup_taken_o); end
    checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b want 0", bus.redirect_valid_o); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", bus.flush_o); end
    checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_rpc: got %h want 0", bus.redirect_pc_o); end
    checks++; if (bus.branch_count_o !== 32'h0) begin errors++; $display("FAIL reset_bc: got %0d want 0", bus.branch_count_o); end
    checks++; if (bus.mispredict_count_o !== 32'h0) begin errors++; $display("FAIL reset_mc: got %0d want 0", bus.mispredict_count_o); end
    rst = 1'b1;
    tick();
  endtask
  task automatic test_beq_mispredict();
    bus.lookup_pc_i = 32'h100;
    drive(2'b01, 1'b0, 1'b0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
    checks++; if (bus.lookup_taken_o !== 1'b0) begin errors++; $display("FAIL beq_no_bypass: got %b want 0", bus.lookup_taken_o); end
    tick();
    idle();
    checks++; if (bus.redirect_valid_o !== 1'b1) begin errors++; $display("FAIL beq_rv: got %b want 1", bus.redirect_valid_o); end
    checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL beq_flush: got %b want 1", bus.flush_o); end
    checks++; if (bus.redirect_pc_o !== 32'h120) begin errors++; $display("FAIL beq_rpc: got %h want 120", bus.redirect_pc_o); end
    checks++; if (bus.lookup_taken_o !== 1'b1) begin errors++; $display("FAIL beq_bht: got %b want 1", bus.lookup_taken_o); end
    tick();
    checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL beq_pulse_end: got %b want 0", bus.redirect_valid_o); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL beq_flush_end: got %b want 0", bus.flush_o); end
    checks++; if (bus.redirect_pc_o !== 32'h120) begin errors++; $display("FAIL beq_rpc_hold: got %h want 120", bus.redirect_pc_o); end
  endtask
  task automatic test_bht_saturate();
    logic exp_t;
    bus.lookup_pc_i = 32'h204;
    drive(2'b10, 1'b0, 1'b0, 32'd7, 32'd7, 32'h204, 32'h10, 1'b0, 32'h0);
    tick();
    idle();
    checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL bne_nt_rv: got %b want 0", bus.redirect_valid_o); end
    checks++; if (bus.lookup_taken_o !== 1'b0) begin errors++; $display("FAIL bne_nt_bht: got %b want 0", bus.lookup_taken_o); end
    for (int i = 0; i < 4; i++) begin
      exp_t = (i > 0);
      drive(2'b01, 1'b0, 1'b0, 32'd7, 32'd7, 32'h204, 32'h10, 1'b1, 32'h214);
      tick();
      idle();
      checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL sat_taken_rv[%0d]: got %b want 0", i, bus.redirect_valid_o); end
      checks++; if (bus.lookup_taken_o !== exp_t) begin errors++; $display("FAIL sat_taken_bht[%0d]: got %b want %b", i, bus.lookup_taken_o, exp_t); end
    end
    for (int i = 0; i < 2; i++) begin
      exp_t = (i == 0);
      drive(2'b01, 1'b0, 1'b0, 32'd7, 32'd8, 32'h204, 32'h10, 1'b0, 32'h0);
      tick();
      idle();
      checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL sat_nt_rv[%0d]: got %b want 0", i, bus.redirect_valid_o); end
      checks++; if (bus.lookup_taken_o !== exp_t) begin errors++; $display("FAIL sat_nt_bht[%0d]: got %b want %b", i, bus.lookup_taken_o, exp_t); end
    end
  endtask
  task automatic test_jalr();
    bus.lookup_pc_i = 32'h308;
    drive(2'b00, 1'b1, 1'b1, 32'h1003, 32'h0, 32'h308, 32'h4, 1'b1, 32'h1006);
    tick();
    idle();
    checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL jalr_ok_rv: got %b want 0", bus.redirect_valid_o); end
    drive(2'b00, 1'b1, 1'b1, 32'h1003, 32'h0, 32'h308, 32'h4, 1'b1, 32'h2000);
    tick();
    idle();
    checks++; if (bus.redirect_valid_o !== 1'b1) begin errors++; $display("FAIL jalr_bad_rv: got %b want 1", bus.redirect_valid_o); end
    checks++; if (bus.redirect_pc_o !== 32'h1006) begin errors++; $display("FAIL jalr_bad_rpc: got %h want 1006", bus.redirect_pc_o); end
    checks++; if (bus.lookup_taken_o !== 1'b0) begin errors++; $display("FAIL jalr_bht: got %b want 0", bus.lookup_taken_o); end
    tick();
  endtask
  task automatic test_blt_signed();
    drive(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h400, 32'h40, 1'b0, 32'h0);
    tick();
    idle();
    checks++; if (bus.redirect_valid_o !== 1'b1) begin errors++; $display("FAIL blt_t_rv: got %b want 1", bus.redirect_valid_o); end
    checks++; if (bus.redirect_pc_o !== 32'h440) begin errors++; $display("FAIL blt_t_rpc: got %h want 440", bus.redirect_pc_o); end
    tick();
    drive(2'b11, 1'b0, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h400, 32'h40, 1'b1, 32'h440);
    tick();
    idle();
    checks++; if (bus.redirect_valid_o !== 1'b1) begin errors++; $display("FAIL blt_nt_rv: got %b want 1", bus.redirect_valid_o); end
    checks++; if (bus.redirect_pc_o !== 32'h404) begin errors++; $display("FAIL blt_nt_rpc: got %h want 404", bus.redirect_pc_o); end
    tick();
  endtask
  task automatic test_pred_nonbranch();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h600, 32'h0, 1'b1, 32'h700);
    tick();
    idle();
    checks++; if (bus.redirect_valid_o !== 1'b1) begin errors++; $display("FAIL nonbr_rv: got %b want 1", bus.redirect_valid_o); end
    checks++; if (bus.redirect_pc_o !== 32'h604) begin errors++; $display("FAIL nonbr_rpc: got %h want 604", bus.redirect_pc_o); end
    tick();
  endtask
  task automatic test_back_to_back();
    bus.lookup_pc_i = 32'h310;
    drive(2'b01, 1'b0, 1'b0, 32'd3, 32'd3, 32'h30C, 32'h40, 1'b0, 32'h0);
    tick();
    drive(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h310, 32'h80, 1'b0, 32'h0);
    checks++; if (bus.redirect_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_first_rv: got %b want 1", bus.redirect_valid_o); end
    checks++; if (bus.redirect_pc_o !== 32'h34C) begin errors++; $display("FAIL b2b_first_rpc: got %h want 34c", bus.redirect_pc_o); end
    tick();
    idle();
    checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_masked_rv: got %b want 0", bus.redirect_valid_o); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL b2b_masked_flush: got %b want 0", bus.flush_o); end
    checks++; if (bus.lookup_taken_o !== 1'b0) begin errors++; $display("FAIL b2b_masked_bht: got %b want 0", bus.lookup_taken_o); end
    drive(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h310, 32'h80, 1'b0, 32'h0);
    bus.stall_i = 1'b1;
    tick();
    idle();
    checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL stall_rv: got %b want 0", bus.redirect_valid_o); end
    checks++; if (bus.lookup_taken_o !== 1'b0) begin errors++; $display("FAIL stall_bht: got %b want 0", bus.lookup_taken_o); end
    drive(2'b01, 1'b0, 1'b0, 32'd3, 32'd3, 32'h700, 32'h10, 1'b0, 32'h0);
    tick();
    bus.stall_i = 1'b1;
    checks++; if (bus.redirect_valid_o !== 1'b1) begin errors++; $display("FAIL stall_pulse_rv: got %b want 1", bus.redirect_valid_o); end
    tick();
    checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL stall_pulse_len: got %b want 0", bus.redirect_valid_o); end
    idle();
    tick();
  endtask
  task automatic test_perf();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(2'b01, 1'b0, 1'b0, 32'd1, 32'd1, 32'h500, 32'h8, 1'b1, 32'h508);
    tick();
    drive(2'b10, 1'b0, 1'b0, 32'd1, 32'd1, 32'h504, 32'h8, 1'b0, 32'h0);
    tick();
    drive(2'b01, 1'b0, 1'b0, 32'd2, 32'd2, 32'h508, 32'h8, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    drive(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h50C, 32'h100, 1'b1, 32'h60C);
    tick();
    idle();
    tick();
    checks++; if (bus.branch_count_o !== EXP_BC) begin errors++; $display("FAIL perf_bc: got %0d want %0d", bus.branch_count_o, EXP_BC); end
    checks++; if (bus.mispredict_count_o !== EXP_MC) begin errors++; $display("FAIL perf_mc: got %0d want %0d", bus.mispredict_count_o, EXP_MC); end
    drive(2'b01, 1'b0, 1'b0, 32'd2, 32'd2, 32'h508, 32'h8, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_rv: got %b want 0", bus.redirect_valid_o); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rst_mid_flush: got %b want 0", bus.flush_o); end
    checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL rst_mid_rpc: got %h want 0", bus.redirect_pc_o); end
    checks++; if (bus.branch_count_o !== 32'h0) begin errors++; $display("FAIL rst_mid_bc: got %0d want 0", bus.branch_count_o); end
    checks++; if (bus.mispredict_count_o !== 32'h0) begin errors++; $display("FAIL rst_mid_mc: got %0d want 0", bus.mispredict_count_o); end
    rst = 1'b1;
    idle();
    tick();
    checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_after_rv: got %b want 0", bus.redirect_valid_o); end
  endtask
  initial begin
    idle();
    bus.lookup_pc_i = 32'h0;
    test_reset();
    test_beq_mispredict();
    test_bht_saturate();
    test_jalr();
    test_blt_signed();
    test_pred_nonbranch();
    test_back_to_back();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
